student_ram8: RTL and testbench



---
 rtl/student_ram8_pkg.sv | 9 +
 rtl/student_register.sv | 34 +++
 rtl/student_ram8.sv | 40 ++++
 tb/tb_student_ram8.sv | 114 +++++++++++
 4 files changed

// File: rtl/student_ram8_pkg.sv
// Shared constants for the student memory family.
// Reused by RAM8, RAM64 and larger memories.
package student_ram8_pkg;

  localparam int WORD_WIDTH  = 16;
  localparam int RAM8_DEPTH  = 8;
  localparam int RAM8_ADDR_W = 3;

endpackage

// File: rtl/student_register.sv
// WIDTH-bit word register with sync active-high clear.
// Ports: clk, reset, load, in (write data), out (stored word).
module student_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = in;
    end
  end

  // Clear wins over a coincident load.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign out = word_q;

endmodule

// File: rtl/student_ram8.sv
// Eight-word read/write memory; sync write, comb read.
// Ports: clk, reset, in, load, address, out.
module student_ram8
  import student_ram8_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic [RAM8_ADDR_W-1:0] address,
  output logic [WIDTH-1:0]       out
);

  logic [RAM8_DEPTH-1:0] load_sel;
  logic [WIDTH-1:0]      word [RAM8_DEPTH];

  // Demux: at most one word sees the load strobe.
  always_comb begin
    load_sel          = '0;
    load_sel[address] = load;
  end

  for (genvar i = 0; i < RAM8_DEPTH; i++) begin : g_word
    student_register #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk  (clk),
      .reset(reset),
      .load (load_sel[i]),
      .in   (in),
      .out  (word[i])
    );
  end

  // Mux: no write-through; old value shown until the edge.
  assign out = word[address];

endmodule

// File: tb/tb_student_ram8.sv
// Directed self-checking bench for student_ram8.
// Drives just after posedge, checks before the next edge.
module tb_student_ram8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  int n_checks = 0;
  int n_fail   = 0;

  student_ram8 dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in),
    .load   (load),
    .address(address),
    .out    (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a,
                    input logic [15:0] exp);
    address = a;
    #1;
    check($sformatf("%s[%0d]", tag, a), out, exp);
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    in      = 16'h0;
    address = 3'd0;
    tick();
    reset = 1'b0;

    for (int k = 0; k < 8; k++) rd("rst_sweep", 3'(k), 16'h0000);

    for (int k = 0; k < 8; k++) wr(3'(k), 16'(16'h1111 * k));
    for (int k = 0; k < 8; k++) rd("readback", 3'(k), 16'(16'h1111 * k));

    wr(3'd5, 16'hBEEF);
    rd("iso", 3'd4, 16'h4444);
    rd("iso", 3'd5, 16'hBEEF);
    rd("iso", 3'd6, 16'h6666);

    address = 3'd2;
    in      = 16'hCAFE;
    load    = 1'b1;
    #1;
    check("rdw_before", out, 16'h2222);
    tick();
    check("rdw_after", out, 16'hCAFE);
    load = 1'b0;

    address = 3'd3;
    in      = 16'hFFFF;
    load    = 1'b1;
    address = 3'd6;
    #1;
    check("rdw_other_addr", out, 16'h6666);
    address = 3'd3;
    load    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hold", out, 16'h3333);
    end

    wr(3'd1, 16'h0A0A);
    wr(3'd1, 16'h0B0B);
    rd("last_wins", 3'd1, 16'h0B0B);

    reset   = 1'b1;
    load    = 1'b1;
    address = 3'd7;
    in      = 16'h1234;
    tick();
    reset = 1'b0;
    load  = 1'b0;
    for (int k = 0; k < 8; k++) rd("rst_prio", 3'(k), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
